// File: rtl/mvm_rx_arbiter.sv
// Packet-level round-robin arbiter sharing one MVM AXI-Stream rx port among NREQ requesters.
// A grant is held until the tlast flit transfers; the output is a registered slice.
module mvm_rx_arbiter #(
  parameter int unsigned NREQ  = 4,
  parameter int unsigned NREQW = $clog2(NREQ),
  parameter int unsigned DATAW = 512,
  parameter int unsigned BYTEW = 8,
  parameter int unsigned IDW   = 32,
  parameter int unsigned DESTW = 12,
  parameter int unsigned USERW = 75
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [NREQ-1:0]        s_axis_tvalid,
  input  logic [NREQ*DATAW-1:0]  s_axis_tdata,
  input  logic [NREQ*BYTEW-1:0]  s_axis_tstrb,
  input  logic [NREQ*BYTEW-1:0]  s_axis_tkeep,
  input  logic [NREQ*IDW-1:0]    s_axis_tid,
  input  logic [NREQ*DESTW-1:0]  s_axis_tdest,
  input  logic [NREQ*USERW-1:0]  s_axis_tuser,
  input  logic [NREQ-1:0]        s_axis_tlast,
  output logic [NREQ-1:0]        s_axis_tready,
  output logic                   m_axis_tvalid,
  output logic [DATAW-1:0]       m_axis_tdata,
  output logic [BYTEW-1:0]       m_axis_tstrb,
  output logic [BYTEW-1:0]       m_axis_tkeep,
  output logic [IDW-1:0]         m_axis_tid,
  output logic [DESTW-1:0]       m_axis_tdest,
  output logic [USERW-1:0]       m_axis_tuser,
  output logic                   m_axis_tlast,
  input  logic                   m_axis_tready,
  output logic [NREQW-1:0]       grant_id,
  output logic                   busy
);

  typedef enum logic [0:0] {StIdle, StLocked} state_e;

  state_e           state_q, state_d;
  logic [NREQW-1:0] rr_q, rr_d;
  logic [NREQW-1:0] grant_q, grant_d;
  logic [NREQW-1:0] winner, cand;
  logic             found;
  logic             out_free;
  logic             xfer;
  int unsigned      gsel;

  logic [DATAW-1:0] sel_data;
  logic [BYTEW-1:0] sel_strb, sel_keep;
  logic [IDW-1:0]   sel_id;
  logic [DESTW-1:0] sel_dest;
  logic [USERW-1:0] sel_user;
  logic             sel_last;

  assign gsel     = 32'(grant_q);
  assign sel_data = s_axis_tdata[gsel*DATAW +: DATAW];
  assign sel_strb = s_axis_tstrb[gsel*BYTEW +: BYTEW];
  assign sel_keep = s_axis_tkeep[gsel*BYTEW +: BYTEW];
  assign sel_id   = s_axis_tid[gsel*IDW +: IDW];
  assign sel_dest = s_axis_tdest[gsel*DESTW +: DESTW];
  assign sel_user = s_axis_tuser[gsel*USERW +: USERW];
  assign sel_last = s_axis_tlast[grant_q];

  // The output slot can take a flit when empty or being drained this cycle.
  assign out_free = !m_axis_tvalid || m_axis_tready;
  assign xfer     = (state_q == StLocked) && s_axis_tvalid[grant_q] && out_free && !rst;

  assign grant_id = grant_q;
  assign busy     = (state_q == StLocked);

  always_comb begin
    s_axis_tready = '0;
    if ((state_q == StLocked) && out_free && !rst) begin
      s_axis_tready[grant_q] = 1'b1;
    end
  end

  // NREQ is a power of two, so the search index wraps by plain overflow.
  always_comb begin
    winner = rr_q;
    found  = 1'b0;
    cand   = '0;
    for (int unsigned k = 0; k < NREQ; k++) begin
      cand = rr_q + NREQW'(k);
      if (!found && s_axis_tvalid[cand]) begin
        winner = cand;
        found  = 1'b1;
      end
    end
  end

  always_comb begin
    state_d = state_q;
    rr_d    = rr_q;
    grant_d = grant_q;
    unique case (state_q)
      StIdle: begin
        if (found) begin
          grant_d = winner;
          state_d = StLocked;
        end
      end
      StLocked: begin
        if (xfer && sel_last) begin
          state_d = StIdle;
          rr_d    = grant_q + 1'b1;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= StIdle;
      rr_q    <= '0;
      grant_q <= '0;
    end else begin
      state_q <= state_d;
      rr_q    <= rr_d;
      grant_q <= grant_d;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      m_axis_tvalid <= 1'b0;
      m_axis_tdata  <= '0;
      m_axis_tstrb  <= '0;
      m_axis_tkeep  <= '0;
      m_axis_tid    <= '0;
      m_axis_tdest  <= '0;
      m_axis_tuser  <= '0;
      m_axis_tlast  <= 1'b0;
    end else if (xfer) begin
      m_axis_tvalid <= 1'b1;
      m_axis_tdata  <= sel_data;
      m_axis_tstrb  <= sel_strb;
      m_axis_tkeep  <= sel_keep;
      m_axis_tid    <= sel_id;
      m_axis_tdest  <= sel_dest;
      m_axis_tuser  <= sel_user;
      m_axis_tlast  <= sel_last;
    end else if (m_axis_tready) begin
      m_axis_tvalid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_mvm_rx_arbiter.sv
// Randomized scoreboard bench for mvm_rx_arbiter: per-requester flit queues feed the DUT,
// a transaction-level arbitration model predicts grants and pushes expected output flits.
module tb_mvm_rx_arbiter;

  localparam int NREQ  = 4;
  localparam int NREQW = 2;
  localparam int DATAW = 512;
  localparam int BYTEW = 8;
  localparam int IDW   = 32;
  localparam int DESTW = 12;
  localparam int USERW = 75;

  typedef struct {
    logic [DATAW-1:0] data;
    logic [BYTEW-1:0] strb;
    logic [BYTEW-1:0] keep;
    logic [IDW-1:0]   id;
    logic [DESTW-1:0] dest;
    logic [USERW-1:0] user;
    logic             last;
    int               src;
  } flit_t;

  logic                  clk;
  logic                  rst;
  logic [NREQ-1:0]       s_axis_tvalid;
  logic [NREQ*DATAW-1:0] s_axis_tdata;
  logic [NREQ*BYTEW-1:0] s_axis_tstrb;
  logic [NREQ*BYTEW-1:0] s_axis_tkeep;
  logic [NREQ*IDW-1:0]   s_axis_tid;
  logic [NREQ*DESTW-1:0] s_axis_tdest;
  logic [NREQ*USERW-1:0] s_axis_tuser;
  logic [NREQ-1:0]       s_axis_tlast;
  logic [NREQ-1:0]       s_axis_tready;
  logic                  m_axis_tvalid;
  logic [DATAW-1:0]      m_axis_tdata;
  logic [BYTEW-1:0]      m_axis_tstrb;
  logic [BYTEW-1:0]      m_axis_tkeep;
  logic [IDW-1:0]        m_axis_tid;
  logic [DESTW-1:0]      m_axis_tdest;
  logic [USERW-1:0]      m_axis_tuser;
  logic                  m_axis_tlast;
  logic                  m_axis_tready;
  logic [NREQW-1:0]      grant_id;
  logic                  busy;

  mvm_rx_arbiter #(
    .NREQ (NREQ),
    .NREQW(NREQW),
    .DATAW(DATAW),
    .BYTEW(BYTEW),
    .IDW  (IDW),
    .DESTW(DESTW),
    .USERW(USERW)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .s_axis_tvalid(s_axis_tvalid),
    .s_axis_tdata (s_axis_tdata),
    .s_axis_tstrb (s_axis_tstrb),
    .s_axis_tkeep (s_axis_tkeep),
    .s_axis_tid   (s_axis_tid),
    .s_axis_tdest (s_axis_tdest),
    .s_axis_tuser (s_axis_tuser),
    .s_axis_tlast (s_axis_tlast),
    .s_axis_tready(s_axis_tready),
    .m_axis_tvalid(m_axis_tvalid),
    .m_axis_tdata (m_axis_tdata),
    .m_axis_tstrb (m_axis_tstrb),
    .m_axis_tkeep (m_axis_tkeep),
    .m_axis_tid   (m_axis_tid),
    .m_axis_tdest (m_axis_tdest),
    .m_axis_tuser (m_axis_tuser),
    .m_axis_tlast (m_axis_tlast),
    .m_axis_tready(m_axis_tready),
    .grant_id     (grant_id),
    .busy         (busy)
  );

  int tests = 0;
  int fails = 0;
  int cyc = 0;

  flit_t src_q[NREQ][$];
  flit_t exp_q[$];
  int    log_src[$];
  int    log_cyc[$];
  bit    present[NREQ];
  int    fire_cyc[NREQ];
  int    delivered = 0;

  bit junk = 1'b1;
  bit chk_en = 1'b0;
  bit rand_rdy = 1'b0;
  int gap_pct = 0;
  int stall_left = 0;

  // Reference model of arbitration state
  bit mdl_locked = 1'b0;
  int mdl_grant = 0;
  int mdl_rr = 0;
  bit mdl_mv = 1'b0;

  bit               prev_stall = 1'b0;
  logic [DATAW-1:0] prev_data;
  logic [USERW-1:0] prev_user;
  flit_t            drv_f;
  flit_t            mon_e;

  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #900000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  task automatic chk(input string name, input logic [DATAW-1:0] act,
                     input logic [DATAW-1:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic flit_t rand_flit(input int src, input bit last);
    flit_t f;
    logic [95:0] u;
    for (int w = 0; w < DATAW / 32; w++) f.data[w*32 +: 32] = $urandom;
    u      = {$urandom, $urandom, $urandom};
    f.strb = 8'($urandom);
    f.keep = 8'($urandom);
    f.id   = $urandom;
    f.dest = 12'($urandom);
    f.user = u[USERW-1:0];
    f.last = last;
    f.src  = src;
    return f;
  endfunction

  task automatic push_pkt(input int r, input int len);
    for (int j = 0; j < len; j++) src_q[r].push_back(rand_flit(r, j == len - 1));
  endtask

  // Stimulus driver: changes inputs 2 time units after each rising edge.
  always @(posedge clk) begin
    #2;
    for (int i = 0; i < NREQ; i++) begin
      if (junk) begin
        drv_f = rand_flit(i, 1'($urandom));
        s_axis_tvalid[i] = 1'($urandom);
      end else begin
        if (!present[i] && src_q[i].size() > 0 && $urandom_range(99) >= 32'(gap_pct))
          present[i] = 1'b1;
        if (present[i]) drv_f = src_q[i][0];
        else drv_f = rand_flit(i, 1'($urandom));
        s_axis_tvalid[i] = present[i];
      end
      s_axis_tdata[i*DATAW +: DATAW] = drv_f.data;
      s_axis_tstrb[i*BYTEW +: BYTEW] = drv_f.strb;
      s_axis_tkeep[i*BYTEW +: BYTEW] = drv_f.keep;
      s_axis_tid[i*IDW +: IDW]       = drv_f.id;
      s_axis_tdest[i*DESTW +: DESTW] = drv_f.dest;
      s_axis_tuser[i*USERW +: USERW] = drv_f.user;
      s_axis_tlast[i]                = drv_f.last;
    end
    if (stall_left > 0) begin
      m_axis_tready = 1'b0;
      stall_left--;
    end else if (junk || rand_rdy) begin
      m_axis_tready = ($urandom_range(3) != 0);
    end else begin
      m_axis_tready = 1'b1;
    end
  end

  // Monitor, scoreboard and model step; all signals are stable at the falling edge.
  always @(negedge clk) begin
    if (chk_en) begin
      logic [NREQ-1:0] er;
      bit found;
      er = '0;
      if (!rst && mdl_locked && (!mdl_mv || m_axis_tready)) er[mdl_grant] = 1'b1;
      chk("s_tready", DATAW'(s_axis_tready), DATAW'(er));
      chk("m_tvalid", DATAW'(m_axis_tvalid), DATAW'(mdl_mv));
      chk("busy", DATAW'(busy), DATAW'(mdl_locked));
      chk("grant_id", DATAW'(grant_id), DATAW'(mdl_grant));
      if (prev_stall) begin
        chk("stall_tdata", m_axis_tdata, prev_data);
        chk("stall_tuser", DATAW'(m_axis_tuser), DATAW'(prev_user));
      end
      prev_stall = m_axis_tvalid && !m_axis_tready && !rst;
      prev_data  = m_axis_tdata;
      prev_user  = m_axis_tuser;

      if (!rst && m_axis_tvalid && m_axis_tready) begin
        if (exp_q.size() == 0) begin
          tests++;
          fails++;
          $display("FAIL unexpected_flit: got tid %0h expected no flit", m_axis_tid);
        end else begin
          mon_e = exp_q.pop_front();
          chk("out_tdata", m_axis_tdata, mon_e.data);
          chk("out_tstrb", DATAW'(m_axis_tstrb), DATAW'(mon_e.strb));
          chk("out_tkeep", DATAW'(m_axis_tkeep), DATAW'(mon_e.keep));
          chk("out_tid", DATAW'(m_axis_tid), DATAW'(mon_e.id));
          chk("out_tdest", DATAW'(m_axis_tdest), DATAW'(mon_e.dest));
          chk("out_tuser", DATAW'(m_axis_tuser), DATAW'(mon_e.user));
          chk("out_tlast", DATAW'(m_axis_tlast), DATAW'(mon_e.last));
          log_src.push_back(mon_e.src);
          log_cyc.push_back(cyc);
          delivered++;
        end
      end

      if (rst) begin
        for (int i = 0; i < NREQ; i++) begin
          src_q[i].delete();
          present[i] = 1'b0;
        end
        exp_q.delete();
        mdl_locked = 1'b0;
        mdl_grant  = 0;
        mdl_rr     = 0;
        mdl_mv     = 1'b0;
      end else begin
        if (!mdl_locked) begin
          if (m_axis_tready) mdl_mv = 1'b0;
          found = 1'b0;
          for (int k = 0; k < NREQ; k++) begin
            if (!found && s_axis_tvalid[(mdl_rr + k) % NREQ]) begin
              mdl_grant = (mdl_rr + k) % NREQ;
              found = 1'b1;
            end
          end
          if (found) mdl_locked = 1'b1;
        end else if (s_axis_tvalid[mdl_grant] && (!mdl_mv || m_axis_tready)) begin
          mdl_mv = 1'b1;
          if (src_q[mdl_grant].size() == 0) begin
            tests++;
            fails++;
            $display("FAIL model_xfer: got transfer from %0d expected queued flit", mdl_grant);
          end else begin
            exp_q.push_back(src_q[mdl_grant][0]);
            if (src_q[mdl_grant][0].last) begin
              mdl_locked = 1'b0;
              mdl_rr = (mdl_grant + 1) % NREQ;
            end
          end
        end else if (m_axis_tready) begin
          mdl_mv = 1'b0;
        end
        for (int i = 0; i < NREQ; i++) begin
          if (present[i] && s_axis_tvalid[i] && s_axis_tready[i]) begin
            void'(src_q[i].pop_front());
            present[i] = 1'b0;
            fire_cyc[i] = cyc + 1;
          end
        end
      end
    end
  end

  task automatic wait_drain(input string name, input int budget);
    int n = 0;
    while ((src_q[0].size() + src_q[1].size() + src_q[2].size() + src_q[3].size()
            + exp_q.size()) > 0 && n < budget) begin
      @(posedge clk);
      #1;
      n++;
    end
    @(posedge clk);
    #1;
    tests++;
    if (n >= budget) begin
      fails++;
      $display("FAIL %s_drain: got %0d flits pending expected 0", name, exp_q.size());
    end
  endtask

  task automatic wait_size(input int r, input int n, input int budget);
    int c = 0;
    while (src_q[r].size() > n && c < budget) begin
      @(posedge clk);
      #1;
      c++;
    end
    tests++;
    if (c >= budget) begin
      fails++;
      $display("FAIL wait_q%0d: got size %0d expected %0d", r, src_q[r].size(), n);
    end
  endtask

  task automatic clear_logs();
    log_src.delete();
    log_cyc.delete();
  endtask

  initial begin
    flit_t f;
    int req_cyc;
    int total;
    rst = 1'b1;
    m_axis_tready = 1'b0;
    s_axis_tvalid = '0;
    s_axis_tdata = '0;
    s_axis_tstrb = '0;
    s_axis_tkeep = '0;
    s_axis_tid = '0;
    s_axis_tdest = '0;
    s_axis_tuser = '0;
    s_axis_tlast = '0;

    // Reset with random inputs for 3 cycles
    @(posedge clk);
    #1;
    chk_en = 1'b1;
    repeat (2) begin
      @(posedge clk);
      #1;
    end
    rst = 1'b0;
    junk = 1'b0;
    @(negedge clk);
    chk("rst_tdata", m_axis_tdata, '0);
    chk("rst_tstrb", DATAW'(m_axis_tstrb), '0);
    chk("rst_tkeep", DATAW'(m_axis_tkeep), '0);
    chk("rst_tid", DATAW'(m_axis_tid), '0);
    chk("rst_tdest", DATAW'(m_axis_tdest), '0);
    chk("rst_tuser", DATAW'(m_axis_tuser), '0);
    chk("rst_tlast", DATAW'(m_axis_tlast), '0);

    // Single RF-write flit from requester 2
    @(posedge clk);
    #1;
    f.data = {64{8'h01}};
    f.strb = 8'hFF;
    f.keep = 8'hFF;
    f.id   = 32'h0;
    f.dest = 12'h0;
    f.user = {64'hFFFF_FFFF_FFFF_FFFF, 2'b11, 9'h001};
    f.last = 1'b1;
    f.src  = 2;
    clear_logs();
    src_q[2].push_back(f);
    req_cyc = cyc;
    wait_drain("rf", 50);
    chk("rf_xfer_latency", DATAW'(fire_cyc[2] - req_cyc), DATAW'(2));
    chk("rf_count", DATAW'(log_src.size()), DATAW'(1));

    // Fairness: every requester keeps one-flit packets queued
    clear_logs();
    for (int p = 0; p < 3; p++)
      for (int r = 0; r < NREQ; r++) push_pkt(r, 1);
    wait_drain("fair", 300);
    chk("fair_count", DATAW'(log_src.size()), DATAW'(12));
    if (log_src.size() == 12) begin
      chk("fair_first", DATAW'(log_src[0]), DATAW'(3));
      for (int j = 1; j < 12; j++) begin
        chk("fair_order", DATAW'(log_src[j]), DATAW'((log_src[j-1] + 1) % NREQ));
        chk("fair_gap", DATAW'(log_cyc[j] - log_cyc[j-1]), DATAW'(2));
      end
    end

    // Atomicity: requester 0 requests while requester 1 holds a 3-flit packet
    clear_logs();
    push_pkt(1, 3);
    @(posedge clk);
    #1;
    push_pkt(0, 1);
    wait_drain("atom", 100);
    chk("atom_count", DATAW'(log_src.size()), DATAW'(4));
    if (log_src.size() == 4) begin
      for (int j = 0; j < 3; j++) chk("atom_src", DATAW'(log_src[j]), DATAW'(1));
      chk("atom_next", DATAW'(log_src[3]), DATAW'(0));
      chk("atom_gap1", DATAW'(log_cyc[1] - log_cyc[0]), DATAW'(1));
      chk("atom_gap2", DATAW'(log_cyc[2] - log_cyc[1]), DATAW'(1));
      chk("atom_bubble", DATAW'(log_cyc[3] - log_cyc[2]), DATAW'(2));
    end

    // Backpressure: 5-cycle stall mid-packet
    clear_logs();
    push_pkt(3, 4);
    wait_size(3, 2, 50);
    stall_left = 5;
    wait_drain("bp", 100);
    chk("bp_count", DATAW'(log_src.size()), DATAW'(4));

    // Reset on the second flit of a 4-flit packet
    push_pkt(1, 4);
    wait_size(1, 3, 50);
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    @(negedge clk);
    chk("rstmid_tvalid", DATAW'(m_axis_tvalid), '0);
    chk("rstmid_busy", DATAW'(busy), '0);
    @(posedge clk);
    #1;
    clear_logs();
    push_pkt(3, 1);
    push_pkt(0, 1);
    wait_drain("rstmid_rr", 100);
    chk("rstmid_count", DATAW'(log_src.size()), DATAW'(2));
    if (log_src.size() == 2) begin
      chk("rstmid_first", DATAW'(log_src[0]), DATAW'(0));
      chk("rstmid_second", DATAW'(log_src[1]), DATAW'(3));
    end
    clear_logs();
    push_pkt(1, 4);
    wait_drain("resend", 100);
    chk("resend_count", DATAW'(log_src.size()), DATAW'(4));

    // Random traffic with random gaps and random sink readiness
    gap_pct = 30;
    rand_rdy = 1'b1;
    delivered = 0;
    total = 0;
    for (int p = 0; p < 60; p++) begin
      int len;
      len = $urandom_range(4, 1);
      push_pkt($urandom_range(NREQ - 1), len);
      total += len;
    end
    wait_drain("random", 5000);
    chk("random_count", DATAW'(delivered), DATAW'(total));

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
